// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the MEM-stage data-memory port: funct3 codes,
// responder FSM states and access legality/extension helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dm_state_t;

  // Legal size code for the direction and naturally aligned for that size.
  function automatic logic dm_access_ok(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return ~off[0];
      F3_W:    return off == 2'b00;
      F3_BU:   return ~we;
      F3_HU:   return ~we & ~off[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] dm_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'h0, b};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dm_sram.sv
// Synchronous single-port word array with per-byte write enables; read data
// (old contents) appears the cycle after the address is presented.
module dm_sram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic [3:0]      be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_port_ctrl.sv
// MEM-stage data-memory responder: wait-state FSM, byte-lane steering for stores,
// load extension, pipeline stall and one-cycle access error pulse.
module dm_port_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        access_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dm_state_t       state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            req_ok;
  logic            sram_en;
  logic [3:0]      be;
  logic [XLEN-1:0] wlane;
  logic [XLEN-1:0] sram_rdata;
  logic [XLEN-1:0] ext;
  logic            unused_addr;

  assign unused_addr = ^addr[31:AW+2];
  assign req_ok      = dm_access_ok(mem_we, funct3, addr[1:0]);
  assign sram_en     = (state_q == BUSY) && (cnt_q == 4'd0);
  assign ext         = dm_extend(f3_q, off_q, sram_rdata);

  always_comb begin
    be    = '0;
    wlane = wdata_q;
    case (f3_q)
      F3_B: begin
        be    = 4'b0001 << off_q;
        wlane = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      F3_W:    be = '1;
      default: be = '0;
    endcase
    if (!we_q) be = '0;
  end

  dm_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk_i  (clk),
    .en_i   (sram_en),
    .be_i   (be),
    .addr_i (idx_q),
    .wdata_i(wlane),
    .rdata_o(sram_rdata)
  );

  // Gated by rst_n so the pipeline is released the instant reset asserts.
  assign stall      = rst_n && (((state_q == IDLE) && mem_req) || (state_q == BUSY));
  // Array read data lands in DONE, so the load result bypasses rdata_q for that cycle.
  assign rdata      = ((state_q == DONE) && !we_q && !err_q) ? ext : rdata_q;
  assign access_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            we_q    <= mem_we;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            if (req_ok) begin
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= BUSY;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
          else               state_q <= DONE;
        end
        DONE: begin
          if (!we_q && !err_q) rdata_q <= ext;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
